numlock_param_sm: RTL and testbench

Parametrised successor to the two-button (U = digit 1, Z = digit 0) number-lock state machine. It accepts a CODE_LEN-digit code entered MSB first, with press/release debounce-by-state. It adds a parametrised open window, a bad-attempt counter and a timed lockout. It sits between the debounced button pulses and the door/LED drive logic on the board top.

---
 rtl/numlock_param_sm.sv | 227 ++++++++++++++++++++++
 tb/tb_numlock_param_sm.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/numlock_param_sm.sv
// numlock_param_sm
//
// Two-button number lock. Button U enters digit 1 and button Z enters
// digit 0. The code is CODE_LEN digits long and is entered MSB first.
// Each digit is accepted on the press and then has to be released
// before the next digit counts. This gives debounce-by-state.
//
// Added over the original lock:
//   - an open window of OPEN_CYCLES cycles,
//   - a saturating count of bad attempts,
//   - a timed lockout of LOCKOUT_CYCLES cycles after MAX_FAILS bad
//     attempts in a row.
//
// Optional feature (macro NUMLOCK_PROG_EN):
//   When the macro is defined, the ports prog_req and prog_code exist.
//   Asserting prog_req in any OPENING cycle stores prog_code as the new
//   code. Reset brings back CODE. When the macro is undefined, the code
//   is the constant CODE.
//
// Interface contract: U and Z are already-debounced levels. They are
// sampled on every rising clk edge. There is no handshake. Every output
// is a registered view of the machine, except the q_* bits, which are a
// plain decode of the state register.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   U, Z       in   "1" and "0" buttons (levels)
//   prog_req   in   (NUMLOCK_PROG_EN only) load prog_code during OPENING
//   prog_code  in   (NUMLOCK_PROG_EN only) new code, CODE_LEN bits
//   q_Idle .. q_Lockout  out  one-hot state bits (the FSM state view)
//   digit_idx  out  digits accepted so far
//   fail_cnt   out  consecutive bad attempts (saturates at MAX_FAILS)
//   open_pulse out  high for the first OPENING cycle only
module numlock_param_sm #(
    parameter int                     CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0]    CODE           = 4'b1011,
    parameter int                     OPEN_CYCLES    = 16,
    parameter int                     MAX_FAILS      = 3,
    parameter int                     LOCKOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              U,
    input  logic                              Z,
`ifdef NUMLOCK_PROG_EN
    input  logic                              prog_req,
    input  logic [CODE_LEN-1:0]               prog_code,
`endif
    output logic                              q_Idle,
    output logic                              q_Get,
    output logic                              q_Wait,
    output logic                              q_Opening,
    output logic                              q_Bad,
    output logic                              q_Lockout,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_idx,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt,
    output logic                              open_pulse
);

    localparam int DW   = $clog2(CODE_LEN + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET     = 3'd1,
        S_WAIT    = 3'd2,
        S_OPENING = 3'd3,
        S_BAD     = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              pulse_q, pulse_d;
    logic [CODE_LEN-1:0] code_r;

    logic              any_btn;
    logic              one_btn;
    logic              both_btn;
    logic [CODE_LEN-1:0] code_shift;
    logic              exp_bit;
    logic              digit_ok;
    logic [FW-1:0]     fail_inc;

    // Code storage. It is a register only when reprogramming is built in.
`ifdef NUMLOCK_PROG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            code_r <= CODE;
        end else if (state_q == S_OPENING && prog_req) begin
            code_r <= prog_code;
        end
    end
`else
    assign code_r = CODE;
`endif

    assign any_btn  = U | Z;
    assign both_btn = U & Z;
    assign one_btn  = U ^ Z;

    // The expected digit is code[CODE_LEN-1-idx]. Shifting the code left
    // by idx puts that digit at the MSB without a negative index. When
    // idx is out of range, the shift yields 0, and idx never reaches that
    // range in the states that use exp_bit.
    assign code_shift = code_r << idx_q;
    assign exp_bit    = code_shift[CODE_LEN-1];
    assign digit_ok   = one_btn && (U == exp_bit);

    assign fail_inc = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fail_d  = fail_q;
        timer_d = '0;          // timer reads zero outside its own states
        pulse_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (both_btn) begin
                    state_d = S_BAD;
                    idx_d   = '0;
                    fail_d  = fail_inc;
                end else if (digit_ok) begin
                    state_d = S_GET;
                    idx_d   = DW'(1);
                end
                // A wrong single press in IDLE is ignored and does not count as a failure.
            end
            S_GET: begin
                if (!any_btn) begin
                    if (idx_q == DW'(CODE_LEN)) begin
                        state_d = S_OPENING;
                        pulse_d = 1'b1;
                        idx_d   = '0;
                        fail_d  = '0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (any_btn) begin
                    if (digit_ok) begin
                        state_d = S_GET;
                        idx_d   = idx_q + DW'(1);
                    end else begin
                        state_d = S_BAD;
                        idx_d   = '0;
                        fail_d  = fail_inc;
                    end
                end
            end
            S_BAD: begin
                if (!any_btn) begin
                    state_d = (fail_q == FW'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_OPENING: begin
                if (timer_q == TW'(OPEN_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                // An illegal encoding recovers to IDLE on the next edge.
                state_d = S_IDLE;
                idx_d   = '0;
                fail_d  = '0;
            end
        endcase
    end

    // State decode. An illegal encoding shows as IDLE, so exactly one
    // q_* bit is high even in the cycle before recovery.
    always_comb begin
        q_Idle    = 1'b0;
        q_Get     = 1'b0;
        q_Wait    = 1'b0;
        q_Opening = 1'b0;
        q_Bad     = 1'b0;
        q_Lockout = 1'b0;
        case (state_q)
            S_GET:     q_Get     = 1'b1;
            S_WAIT:    q_Wait    = 1'b1;
            S_OPENING: q_Opening = 1'b1;
            S_BAD:     q_Bad     = 1'b1;
            S_LOCKOUT: q_Lockout = 1'b1;
            default:   q_Idle    = 1'b1;
        endcase
    end

    assign digit_idx  = idx_q;
    assign fail_cnt   = fail_q;
    assign open_pulse = pulse_q;

endmodule

// File: tb/tb_numlock_param_sm.sv
// Testbench for numlock_param_sm.
//
// The driver changes the inputs on the falling clock edge. At the same
// time it advances a reference model of the lock and pushes the
// expected post-edge snapshot {q bits, digit_idx, fail_cnt, open_pulse}
// into exp_q. The monitor samples the DUT 1 ns after each rising edge
// and checks it against the oldest queued snapshot.
module tb_numlock_param_sm;

    localparam int CODE_LEN       = 4;
    localparam logic [CODE_LEN-1:0] CODE = 4'b1011;
    localparam int OPEN_CYCLES    = 16;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 64;
    localparam int IW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int W  = 6 + IW + FW + 1;

    // Model modes. The position of each mode equals its bit in the
    // packed q vector {Lockout, Opening, Bad, Wait, Get, Idle}.
    localparam int M_IDLE = 0, M_GET = 1, M_WAIT = 2, M_BAD = 3, M_OPEN = 4, M_LOCK = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_u = 1'b0;
    logic btn_z = 1'b0;
    logic prog_req_s = 1'b0;
    logic [CODE_LEN-1:0] prog_code_s = '0;
    always #5 clk = ~clk;

    logic q_idle, q_get, q_wait, q_opening, q_bad, q_lockout, open_pulse;
    logic [IW-1:0] digit_idx;
    logic [FW-1:0] fail_cnt;

    numlock_param_sm #(
        .CODE_LEN(CODE_LEN), .CODE(CODE), .OPEN_CYCLES(OPEN_CYCLES),
        .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .U(btn_u), .Z(btn_z),
`ifdef NUMLOCK_PROG_EN
        .prog_req(prog_req_s), .prog_code(prog_code_s),
`endif
        .q_Idle(q_idle), .q_Get(q_get), .q_Wait(q_wait), .q_Opening(q_opening),
        .q_Bad(q_bad), .q_Lockout(q_lockout), .digit_idx(digit_idx),
        .fail_cnt(fail_cnt), .open_pulse(open_pulse)
    );

    // ---------------- reference model ----------------
    int m_mode = M_IDLE;
    int m_idx = 0;
    int m_fails = 0;
    int m_remain = 0;      // cycles left in OPENING/LOCKOUT
    logic m_pulse = 1'b0;
    logic [CODE_LEN-1:0] m_code = CODE;

    function automatic logic want_digit(input int idx);
        return m_code[CODE_LEN-1-idx];
    endfunction

    task automatic model_bad();
        m_mode  = M_BAD;
        m_idx   = 0;
        m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
    endtask

    task automatic model_step(input logic u, input logic z, input logic rst);
        logic single;
        single = u ^ z;
        m_pulse = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_idx = 0; m_fails = 0; m_remain = 0; m_code = CODE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (u && z) model_bad();
                    else if (single && u == want_digit(0)) begin m_mode = M_GET; m_idx = 1; end
                end
                M_GET: if (!(u || z)) begin
                    if (m_idx == CODE_LEN) begin
                        m_mode = M_OPEN; m_remain = OPEN_CYCLES; m_pulse = 1'b1;
                        m_idx = 0; m_fails = 0;
                    end else m_mode = M_WAIT;
                end
                M_WAIT: if (u || z) begin
                    if (single && u == want_digit(m_idx)) begin m_mode = M_GET; m_idx++; end
                    else model_bad();
                end
                M_BAD: if (!(u || z)) begin
                    if (m_fails == MAX_FAILS) begin m_mode = M_LOCK; m_remain = LOCKOUT_CYCLES; end
                    else m_mode = M_IDLE;
                end
                M_OPEN: begin
`ifdef NUMLOCK_PROG_EN
                    if (prog_req_s) m_code = prog_code_s;
`endif
                    m_remain--;
                    if (m_remain == 0) m_mode = M_IDLE;
                end
                default: begin
                    m_remain--;
                    if (m_remain == 0) begin m_mode = M_IDLE; m_fails = 0; end
                end
            endcase
        end
    endtask

    function automatic logic [W-1:0] model_snapshot();
        logic [5:0] oh;
        oh = 6'd1 << m_mode;
        return {oh, IW'(m_idx), FW'(m_fails), m_pulse};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;

    initial begin
        logic [W-1:0] got, exp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {q_lockout, q_opening, q_bad, q_wait, q_get, q_idle, digit_idx, fail_cnt, open_pulse};
                checks++;
                if (got === exp) passes++;
                else $display("FAIL snapshot cyc=%0d: got q=%b idx=%0d fail=%0d pulse=%b, expected q=%b idx=%0d fail=%0d pulse=%b",
                              cyc, got[W-1 -: 6], got[IW+FW:FW+1], got[FW:1], got[0],
                              exp[W-1 -: 6], exp[IW+FW:FW+1], exp[FW:1], exp[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic u, input logic z, input logic rst);
        @(negedge clk);
        btn_u = u; btn_z = z; reset = rst;
        model_step(u, z, rst);
        exp_q.push_back(model_snapshot());
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic u, input logic z, input int hold, input int rel);
        repeat (hold) step(u, z, 1'b0);
        repeat (rel) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [CODE_LEN-1:0] c);
        for (int i = CODE_LEN - 1; i >= 0; i--)
            press(c[i], !c[i], $urandom_range(1, 3), $urandom_range(1, 2));
    endtask

    // U then U again is wrong at digit 2 of 1011, so it is one bad attempt.
    task automatic bad_attempt();
        press(1'b1, 1'b0, 1, 1);
        press(1'b1, 1'b0, 2, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        // Correct entry with single-cycle holds, then the full open window.
        for (int i = CODE_LEN - 1; i >= 0; i--) press(CODE[i], !CODE[i], 1, 1);
        idle(OPEN_CYCLES + 4);

        // Wrong second digit held 5 cycles.
        press(1'b1, 1'b0, 1, 1);
        press(1'b1, 1'b0, 5, 3);

        // Reach lockout, toggling U the whole time, including across the exit.
        bad_attempt();
        bad_attempt();
        for (int i = 0; i < LOCKOUT_CYCLES + 6; i++) step(i[0], 1'b0, 1'b0);
        idle(4);

        // U&Z while in WAIT with digit_idx = 2.
        press(1'b1, 1'b0, 1, 1);
        press(1'b0, 1'b1, 1, 1);
        press(1'b1, 1'b1, 2, 2);

        // Reset while in GET with digit_idx = 3.
        press(1'b1, 1'b0, 1, 1);
        press(1'b0, 1'b1, 1, 1);
        press(1'b1, 1'b0, 2, 0);
        step(1'b1, 1'b0, 1'b1);
        idle(3);

        // Reset in the middle of a lockout.
        repeat (MAX_FAILS) bad_attempt();
        idle(10);
        step(1'b0, 1'b0, 1'b1);
        idle(3);

`ifdef NUMLOCK_PROG_EN
        // Reprogram to 0110 during OPENING.
        enter_code(CODE);
        idle(3);
        @(negedge clk); prog_req_s = 1'b1; prog_code_s = 4'b0110;
        model_step(1'b0, 1'b0, 1'b0); exp_q.push_back(model_snapshot());
        btn_u = 1'b0; btn_z = 1'b0; reset = 1'b0;
        @(negedge clk); prog_req_s = 1'b0;
        model_step(1'b0, 1'b0, 1'b0); exp_q.push_back(model_snapshot());
        idle(OPEN_CYCLES);
        enter_code(CODE);
        idle(3);
        enter_code(4'b0110);
        idle(OPEN_CYCLES + 2);
        // prog_req outside OPENING must be ignored.
        prog_req_s = 1'b1; prog_code_s = 4'b0000;
        idle(2);
        prog_req_s = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        enter_code(CODE);
        idle(OPEN_CYCLES + 2);
`endif

        // Randomised sessions.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: begin enter_code(CODE); idle($urandom_range(0, 20)); end
                1: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(1, 4), $urandom_range(0, 3));
                2: begin
                    for (int i = 0; i < $urandom_range(1, 3); i++)
                        press(CODE[CODE_LEN-1-i], !CODE[CODE_LEN-1-i], 1, 1);
                    press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1);
                end
                3: idle($urandom_range(1, 8));
                4: repeat ($urandom_range(1, 6))
                       step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                default: step(1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 7) == 0));
            endcase
        end
        idle(LOCKOUT_CYCLES + 2);

        // Let the monitor drain the queue, with a bound.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d snapshots left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
